mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_W, 32, register, HI/LO and bus data width (multiple of 8)
- ADDR_W, 32, bus address width
- RADDR_W, 5, register-file address width
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  EX presents an instruction
- in_ready  out  1  block can accept an instruction
- in_op  in  4  memory op code from mem_pkg: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW
- in_addr  in  ADDR_W  effective address
- in_sdata  in  DATA_W  store data, right-aligned
- in_wdata, in_waddr, in_wen  in  DATA_W, RADDR_W, 1  register writeback from EX
- in_hi, in_lo, in_hilo_en  in  DATA_W, DATA_W, 1  HI/LO writeback from EX
- req_valid  out  1  data-bus request
- req_ready  in  1  bus accepts the request
- req_wr  out  1  1 = store
- req_addr  out  ADDR_W  word-aligned address
- req_wstrb  out  DATA_W/8  byte-lane enables
- req_wdata  out  DATA_W  lane-replicated store data
- resp_valid  in  1  read data or write acknowledge present
- resp_rdata  in  DATA_W  read word
- out_valid  out  1  one-cycle writeback pulse
- out_wdata, out_waddr, out_wen  out  DATA_W, RADDR_W, 1  to WB
- out_hi, out_lo, out_hilo_en  out  DATA_W, DATA_W, 1  to WB
- exc_adel, exc_ades, exc_badvaddr  out  1, 1, ADDR_W  address exceptions

Function
REQ-003 The block SHALL hold one instruction at a time; a transfer occurs when in_valid and in_ready are both high; in_ready SHALL be high only in state IDLE.
REQ-004 FSM states SHALL be IDLE, REQ, WAIT, with these transitions: IDLE->REQ on acceptance of a load or store; REQ->WAIT when req_ready is high; WAIT->IDLE when resp_valid is high. Acceptance of NONE SHALL leave the FSM in IDLE.
REQ-005 A NONE op SHALL produce out_valid, with registered copies of all in_* writeback fields, exactly 1 cycle after acceptance.
REQ-006 Bus request fields:
- req_valid SHALL be high exactly while the FSM is in REQ.
- req_addr, req_wr, req_wstrb and req_wdata SHALL remain stable from REQ entry until the handshake.
- resp_valid SHALL be ignored outside WAIT.
REQ-007 Byte lanes and store data:
- Byte ops: lane in_addr[1:0]. Half ops: lanes {addr[1],0} and {addr[1],1}. Word ops: all lanes.
- Store data SHALL be replicated across lanes.
- Loads SHALL drive req_wstrb = 0.
REQ-008 Load result: selected byte or half of resp_rdata, sign-extended for LB/LH and zero-extended for LBU/LHU, placed in out_wdata.
REQ-009 Completion pulse:
- out_valid SHALL pulse 1 cycle after the cycle in which resp_valid is sampled in WAIT.
- Stores SHALL force out_wen = 0.
- HI/LO fields SHALL pass through unchanged for all ops.
REQ-010 When out_valid is low, out_wen and out_hilo_en SHALL be 0.
REQ-011 Minimum load/store latency (acceptance to out_valid) SHALL be 3 cycles, with req_ready and resp_valid each high on their first eligible cycle.

Reset
REQ-012 With rst high at a clock edge:
- The FSM SHALL go to IDLE.
- All outputs SHALL be 0, with in_ready = 1 on the first cycle after rst is released.
REQ-013 Reset during REQ or WAIT SHALL abandon the transaction, with req_valid low from the next cycle; a late resp_valid SHALL be ignored.

Configuration
REQ-014 With MEM_ADDR_EXC_EN defined:
- A misaligned access (half with addr[0] = 1, word with addr[1:0] != 0) SHALL issue no bus request.
- It SHALL pulse exc_adel (load) or exc_ades (store), together with out_valid, 1 cycle after acceptance.
- out_wen SHALL be 0 and exc_badvaddr SHALL equal in_addr.
REQ-015 Without MEM_ADDR_EXC_EN:
- The exception outputs SHALL be tied to 0.
- Misaligned addresses SHALL be forced aligned by clearing the offending low bits.

Structure
REQ-016 Package mem_pkg SHALL hold the op-code encodings, the FSM state encoding and the lane-count constant.
REQ-017 Sub-module mem_load_align SHALL be the only sub-module: combinational lane extraction and sign/zero extension.

Verification
REQ-018 Directed scenarios:
- NONE op, in_wdata=0x1234, in_waddr=3, in_wen=1 -> out_valid 1 cycle later with out_wdata=0x1234, out_wen=1.
- LB addr=0x103, rdata=0x80FFFFFF -> req_addr=0x100, req_wstrb=0, out_wdata=0xFFFFFF80; LBU on the same access -> 0x00000080.
- SH addr=0x202, sdata=0xABCD, req_ready delayed 3 cycles -> req fields stable throughout, req_wstrb=0b1100, req_wdata=0xABCDABCD, out_wen=0.
- LW with resp_valid delayed 5 cycles -> in_ready stays low, out_valid occurs 8 cycles after acceptance.
- rst asserted during WAIT, then resp_valid arrives -> no out_valid, in_ready=1 on the first cycle after rst is released.
- MEM_ADDR_EXC_EN: LW addr=0x101 -> no req_valid, exc_adel=1, exc_badvaddr=0x101, out_wen=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage.
// Op codes, FSM state encoding, lane count and op decode helpers.
package mem_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam int unsigned MEM_LANES = 4;
  localparam int unsigned OFF_W = $clog2(MEM_LANES);

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LBU) ||
           (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) ||
           (op == OP_SW);
  endfunction

  function automatic logic [1:0] op_size(input logic [3:0] op);
    logic [1:0] sz;
    sz = SZ_W;
    unique case (1'b1)
      (op == OP_LB) || (op == OP_LBU) || (op == OP_SB): sz = SZ_B;
      (op == OP_LH) || (op == OP_LHU) || (op == OP_SH): sz = SZ_H;
      default: sz = SZ_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane extraction with sign/zero extension (combinational).
// Ports: op_i, off_i (byte offset), rdata_i (bus word) -> data_o.
module mem_load_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        op_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  // Halfword lane ignores off_i[0]: misaligned halves read aligned.
  assign b = rdata_i[{off_i, 3'b000} +: 8];
  assign h = rdata_i[{off_i[1], 4'b0000} +: 16];

  always_comb begin
    data_o = rdata_i;
    unique case (1'b1)
      op_i == OP_LB:
        data_o = {{(DATA_W-8){b[7]}}, b};
      op_i == OP_LBU:
        data_o = {{(DATA_W-8){1'b0}}, b};
      op_i == OP_LH:
        data_o = {{(DATA_W-16){h[15]}}, h};
      op_i == OP_LHU:
        data_o = {{(DATA_W-16){1'b0}}, h};
      default:
        data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: one load/store at a time over a req/resp bus.
// Ports: in_* from EX, req_*/resp_* data bus, out_* to WB, exc_* address
// exceptions. Define MEM_ADDR_EXC_EN to trap misaligned accesses
// instead of silently aligning them.
module mem_access
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_op,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_sdata,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [RADDR_W-1:0]  in_waddr,
  input  logic                in_wen,
  input  logic [DATA_W-1:0]   in_hi,
  input  logic [DATA_W-1:0]   in_lo,
  input  logic                in_hilo_en,
  output logic                req_valid,
  input  logic                req_ready,
  output logic                req_wr,
  output logic [ADDR_W-1:0]   req_addr,
  output logic [DATA_W/8-1:0] req_wstrb,
  output logic [DATA_W-1:0]   req_wdata,
  input  logic                resp_valid,
  input  logic [DATA_W-1:0]   resp_rdata,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_wdata,
  output logic [RADDR_W-1:0]  out_waddr,
  output logic                out_wen,
  output logic [DATA_W-1:0]   out_hi,
  output logic [DATA_W-1:0]   out_lo,
  output logic                out_hilo_en,
  output logic                exc_adel,
  output logic                exc_ades,
  output logic [ADDR_W-1:0]   exc_badvaddr
);

  localparam int NB = DATA_W / 8;

  logic [1:0]         state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [OFF_W-1:0]   off_q, off_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [NB-1:0]      strb_q, strb_d;
  logic [DATA_W-1:0]  sdat_q, sdat_d;

  logic [DATA_W-1:0]  wd_q, wd_d;
  logic [RADDR_W-1:0] wa_q, wa_d;
  logic               we_q, we_d;
  logic [DATA_W-1:0]  hi_q, hi_d;
  logic [DATA_W-1:0]  lo_q, lo_d;
  logic               he_q, he_d;

  logic               ov_q, ov_d;
  logic [DATA_W-1:0]  owd_q, owd_d;
  logic [RADDR_W-1:0] owa_q, owa_d;
  logic               owe_q, owe_d;
  logic [DATA_W-1:0]  ohi_q, ohi_d;
  logic [DATA_W-1:0]  olo_q, olo_d;
  logic               ohe_q, ohe_d;

  logic               accept;
  logic               is_ld;
  logic               is_st;
  logic               is_mem;
  logic               misal;
  logic [1:0]         sz;
  logic [NB-1:0]      strb_in;
  logic [DATA_W-1:0]  rep_in;
  logic [DATA_W-1:0]  ld_data;

  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid & in_ready;
  assign is_ld    = is_load(in_op);
  assign is_st    = is_store(in_op);
  assign is_mem   = is_ld | is_st;
  assign sz       = op_size(in_op);

  // Lane enables; the low bits a size cannot use are simply ignored,
  // which is what aligns misaligned accesses.
  always_comb begin
    strb_in = '0;
    unique case (sz)
      SZ_B: strb_in[in_addr[1:0]] = 1'b1;
      SZ_H: begin
        strb_in[{in_addr[1], 1'b0}] = 1'b1;
        strb_in[{in_addr[1], 1'b1}] = 1'b1;
      end
      default: strb_in = '1;
    endcase
    if (!is_st) strb_in = '0;
  end

  always_comb begin
    rep_in = in_sdata;
    unique case (sz)
      SZ_B: rep_in = {NB{in_sdata[7:0]}};
      SZ_H: rep_in = {(NB/2){in_sdata[15:0]}};
      default: rep_in = in_sdata;
    endcase
  end

`ifdef MEM_ADDR_EXC_EN
  logic              adel_q;
  logic              ades_q;
  logic [ADDR_W-1:0] bad_q;

  assign misal = is_mem &&
    (((sz == SZ_H) && in_addr[0]) ||
     ((sz == SZ_W) && (in_addr[1:0] != 2'b00)));

  always_ff @(posedge clk) begin
    if (rst) begin
      adel_q <= 1'b0;
      ades_q <= 1'b0;
      bad_q  <= '0;
    end else begin
      adel_q <= accept & misal & is_ld;
      ades_q <= accept & misal & is_st;
      if (accept & misal) bad_q <= in_addr;
    end
  end

  assign exc_adel     = adel_q;
  assign exc_ades     = ades_q;
  assign exc_badvaddr = bad_q;
`else
  assign misal        = 1'b0;
  assign exc_adel     = 1'b0;
  assign exc_ades     = 1'b0;
  assign exc_badvaddr = '0;
`endif

  mem_load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .op_i    (op_q),
    .off_i   (off_q),
    .rdata_i (resp_rdata),
    .data_o  (ld_data)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    off_d   = off_q;
    addr_d  = addr_q;
    strb_d  = strb_q;
    sdat_d  = sdat_q;
    wd_d    = wd_q;
    wa_d    = wa_q;
    we_d    = we_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    he_d    = he_q;
    ov_d    = 1'b0;
    owd_d   = owd_q;
    owa_d   = owa_q;
    owe_d   = 1'b0;
    ohi_d   = ohi_q;
    olo_d   = olo_q;
    ohe_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = in_op;
          off_d  = in_addr[1:0];
          addr_d = {in_addr[ADDR_W-1:2], 2'b00};
          strb_d = strb_in;
          sdat_d = rep_in;
          wd_d   = in_wdata;
          wa_d   = in_waddr;
          we_d   = in_wen;
          hi_d   = in_hi;
          lo_d   = in_lo;
          he_d   = in_hilo_en;
          if (is_mem && !misal) begin
            state_d = S_REQ;
          end else begin
            // NONE or trapped access: answer next cycle.
            ov_d  = 1'b1;
            owd_d = in_wdata;
            owa_d = in_waddr;
            owe_d = in_wen & ~is_mem;
            ohi_d = in_hi;
            olo_d = in_lo;
            ohe_d = in_hilo_en;
          end
        end
      end
      S_REQ: begin
        if (req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (resp_valid) begin
          state_d = S_IDLE;
          ov_d    = 1'b1;
          owd_d   = is_load(op_q) ? ld_data : wd_q;
          owa_d   = wa_q;
          owe_d   = we_q & is_load(op_q);
          ohi_d   = hi_q;
          olo_d   = lo_q;
          ohe_d   = he_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_NONE;
      off_q   <= '0;
      addr_q  <= '0;
      strb_q  <= '0;
      sdat_q  <= '0;
      wd_q    <= '0;
      wa_q    <= '0;
      we_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      he_q    <= 1'b0;
      ov_q    <= 1'b0;
      owd_q   <= '0;
      owa_q   <= '0;
      owe_q   <= 1'b0;
      ohi_q   <= '0;
      olo_q   <= '0;
      ohe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
      sdat_q  <= sdat_d;
      wd_q    <= wd_d;
      wa_q    <= wa_d;
      we_q    <= we_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      he_q    <= he_d;
      ov_q    <= ov_d;
      owd_q   <= owd_d;
      owa_q   <= owa_d;
      owe_q   <= owe_d;
      ohi_q   <= ohi_d;
      olo_q   <= olo_d;
      ohe_q   <= ohe_d;
    end
  end

  assign req_valid   = (state_q == S_REQ);
  assign req_wr      = is_store(op_q);
  assign req_addr    = addr_q;
  assign req_wstrb   = strb_q;
  assign req_wdata   = sdat_q;
  assign out_valid   = ov_q;
  assign out_wdata   = owd_q;
  assign out_waddr   = owa_q;
  assign out_wen     = owe_q;
  assign out_hi      = ohi_q;
  assign out_lo      = olo_q;
  assign out_hilo_en = ohe_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus random traffic
// against a behavioural model of the stage and the bus.
module tb_mem_access;
  import mem_pkg::*;

`ifdef MEM_ADDR_EXC_EN
  localparam bit EXC_ON = 1'b1;
`else
  localparam bit EXC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_sdata = '0;
  logic [31:0] in_wdata = '0;
  logic [4:0]  in_waddr = '0;
  logic        in_wen = 1'b0;
  logic [31:0] in_hi = '0;
  logic [31:0] in_lo = '0;
  logic        in_hilo_en = 1'b0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_rdata = '0;
  logic        out_valid;
  logic [31:0] out_wdata;
  logic [4:0]  out_waddr;
  logic        out_wen;
  logic [31:0] out_hi;
  logic [31:0] out_lo;
  logic        out_hilo_en;
  logic        exc_adel;
  logic        exc_ades;
  logic [31:0] exc_badvaddr;

  mem_access dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_addr(in_addr),
    .in_sdata(in_sdata), .in_wdata(in_wdata),
    .in_waddr(in_waddr), .in_wen(in_wen),
    .in_hi(in_hi), .in_lo(in_lo),
    .in_hilo_en(in_hilo_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr),
    .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .out_valid(out_valid), .out_wdata(out_wdata),
    .out_waddr(out_waddr), .out_wen(out_wen),
    .out_hi(out_hi), .out_lo(out_lo),
    .out_hilo_en(out_hilo_en),
    .exc_adel(exc_adel), .exc_ades(exc_ades),
    .exc_badvaddr(exc_badvaddr)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  typedef struct {
    int unsigned cyc;
    logic [31:0] wdata;
    bit          chk_wd;
    logic [4:0]  waddr;
    logic        wen;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        he;
    logic        adel;
    logic        ades;
    logic [31:0] bad;
  } exp_t;

  exp_t q[$];
  exp_t ce;

  function automatic bit m_ld(input logic [3:0] op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
  endfunction

  function automatic bit m_st(input logic [3:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic int m_bytes(input logic [3:0] op);
    if (op inside {OP_LB, OP_LBU, OP_SB}) return 1;
    if (op inside {OP_LH, OP_LHU, OP_SH}) return 2;
    return 4;
  endfunction

  function automatic bit m_mis(input logic [3:0] op,
                               input logic [31:0] a);
    if (!(m_ld(op) || m_st(op))) return 0;
    return (a % m_bytes(op)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] v;
    int          sh;
    v = rd;
    if (m_bytes(op) == 1) begin
      sh = 8 * int'(a % 4);
      v  = (rd >> sh) & 32'hFF;
      if (op == OP_LB && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (m_bytes(op) == 2) begin
      sh = 16 * int'((a / 2) % 2);
      v  = (rd >> sh) & 32'hFFFF;
      if (op == OP_LH && v >= 32'h8000) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_strb(input logic [3:0] op,
                                        input logic [31:0] a);
    if (!m_st(op)) return 4'h0;
    if (m_bytes(op) == 1) return 4'h1 << (a % 4);
    if (m_bytes(op) == 2) return 4'h3 << (2 * ((a / 2) % 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op,
                                          input logic [31:0] sd);
    if (m_bytes(op) == 1) return (sd & 32'hFF) * 32'h01010101;
    if (m_bytes(op) == 2) return (sd & 32'hFFFF) * 32'h00010001;
    return sd;
  endfunction

  // Writeback fields for the next transaction.
  logic [31:0] g_wd, g_hi, g_lo;
  logic [4:0]  g_wa;
  logic        g_we, g_he;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_strb;

  always @(negedge clk) begin
    if (!rst) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        ce = q.pop_front();
        chk("out_valid", out_valid, 1);
        if (ce.chk_wd) chk("out_wdata", out_wdata, ce.wdata);
        chk("out_waddr", out_waddr, ce.waddr);
        chk("out_wen", out_wen, ce.wen);
        chk("out_hi", out_hi, ce.hi);
        chk("out_lo", out_lo, ce.lo);
        chk("out_hilo_en", out_hilo_en, ce.he);
        chk("exc_adel", exc_adel, ce.adel);
        chk("exc_ades", exc_ades, ce.ades);
        if (ce.adel || ce.ades)
          chk("exc_badvaddr", exc_badvaddr, ce.bad);
      end else begin
        chk("idle_out_valid", out_valid, 0);
        chk("idle_out_wen", out_wen, 0);
        chk("idle_hilo_en", out_hilo_en, 0);
        chk("idle_adel", exc_adel, 0);
        chk("idle_ades", exc_ades, 0);
      end
    end
  end

  task automatic run(input logic [3:0] op,
                     input logic [31:0] a,
                     input logic [31:0] sd,
                     input logic [31:0] rdat,
                     input int rdly,
                     input int sdly,
                     output int unsigned t);
    exp_t e;
    bit   ld, st, mis;
    @(posedge clk); #1;
    ld  = m_ld(op);
    st  = m_st(op);
    mis = EXC_ON && m_mis(op, a);
    in_valid   = 1'b1;
    in_op      = op;
    in_addr    = a;
    in_sdata   = sd;
    in_wdata   = g_wd;
    in_waddr   = g_wa;
    in_wen     = g_we;
    in_hi      = g_hi;
    in_lo      = g_lo;
    in_hilo_en = g_he;
    t = cyc;
    chk("in_ready_idle", in_ready, 1);
    e.cyc    = ((ld || st) && !mis) ? t + 3 + rdly + sdly : t + 1;
    e.wdata  = ld ? m_load(op, a, rdat) : g_wd;
    e.chk_wd = !(st || mis);
    e.waddr  = g_wa;
    e.wen    = g_we && !st && !mis;
    e.hi     = g_hi;
    e.lo     = g_lo;
    e.he     = g_he;
    e.adel   = mis && ld;
    e.ades   = mis && st;
    e.bad    = a;
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op    = 4'($urandom);
    in_addr  = $urandom;
    if ((ld || st) && !mis) begin
      for (int i = 0; i <= rdly; i++) begin
        req_ready  = (i == rdly);
        resp_valid = 1'($urandom);
        resp_rdata = $urandom;
        chk("req_valid", req_valid, 1);
        chk("req_addr", req_addr, a & 32'hFFFFFFFC);
        chk("req_wr", req_wr, st);
        chk("req_wstrb", req_wstrb, m_strb(op, a));
        if (st) chk("req_wdata", req_wdata, m_wdata(op, sd));
        chk("busy_req", in_ready, 0);
        seen_addr  = req_addr;
        seen_strb  = req_wstrb;
        seen_wdata = req_wdata;
        @(posedge clk); #1;
      end
      req_ready = 1'b0;
      for (int j = 0; j <= sdly; j++) begin
        chk("req_low_wait", req_valid, 0);
        chk("busy_wait", in_ready, 0);
        resp_valid = (j == sdly);
        resp_rdata = (j == sdly) ? rdat : $urandom;
        @(posedge clk); #1;
      end
      resp_valid = 1'b0;
    end else begin
      chk("no_req", req_valid, 0);
    end
  endtask

  int unsigned t;
  logic [3:0]  rop;
  logic [31:0] ra;

  initial begin
    g_wd = 0; g_wa = 0; g_we = 0;
    g_hi = 0; g_lo = 0; g_he = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_req_wstrb", req_wstrb, 0);
    chk("rst_req_wdata", req_wdata, 0);
    chk("rst_req_wr", req_wr, 0);
    chk("rst_out_wdata", out_wdata, 0);
    chk("rst_out_wen", out_wen, 0);
    chk("rst_exc", {exc_adel, exc_ades, exc_badvaddr}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    g_wd = 32'h1234; g_wa = 5'd3; g_we = 1'b1;
    g_hi = 32'h11; g_lo = 32'h22; g_he = 1'b1;
    run(OP_NONE, 32'h0, 32'h0, 32'h0, 0, 0, t);
    chk("none_valid", out_valid, 1);
    chk("none_wdata", out_wdata, 32'h1234);
    chk("none_wen", out_wen, 1);
    chk("none_lat", cyc - t, 1);

    run(OP_LB, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0, t);
    chk("lb_addr", seen_addr, 32'h100);
    chk("lb_strb", seen_strb, 4'h0);
    chk("lb_data", out_wdata, 32'hFFFFFF80);
    chk("lb_lat", cyc - t, 3);
    run(OP_LBU, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0, t);
    chk("lbu_data", out_wdata, 32'h00000080);

    run(OP_SH, 32'h202, 32'hABCD, 32'h0, 3, 0, t);
    chk("sh_strb", seen_strb, 4'b1100);
    chk("sh_wdata", seen_wdata, 32'hABCDABCD);
    chk("sh_wen", out_wen, 0);
    chk("sh_lat", cyc - t, 6);

    run(OP_LW, 32'h300, 32'h0, 32'hCAFEF00D, 0, 5, t);
    chk("lw_lat", cyc - t, 8);
    chk("lw_data", out_wdata, 32'hCAFEF00D);

    // Reset while waiting for the response; late response ignored.
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = OP_LW; in_addr = 32'h400;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rw_in_ready", in_ready, 1);
    chk("rw_req_valid", req_valid, 0);
    chk("rw_out_valid", out_valid, 0);
    resp_valid = 1'b1;
    resp_rdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    resp_valid = 1'b0;
    chk("rw_late_resp", out_valid, 0);
    chk("rw_in_ready2", in_ready, 1);

    g_we = 1'b1;
    run(OP_LW, 32'h101, 32'h0, 32'h87654321, 0, 0, t);
`ifdef MEM_ADDR_EXC_EN
    chk("adel_flag", exc_adel, 1);
    chk("adel_bad", exc_badvaddr, 32'h101);
    chk("adel_wen", out_wen, 0);
    chk("adel_lat", cyc - t, 1);
`else
    chk("mis_addr", seen_addr, 32'h100);
    chk("mis_data", out_wdata, 32'h87654321);
    chk("mis_exc", exc_adel, 0);
`endif

    for (int n = 0; n < 300; n++) begin
      g_wd = $urandom; g_wa = 5'($urandom); g_we = 1'($urandom);
      g_hi = $urandom; g_lo = $urandom; g_he = 1'($urandom);
      rop = 4'($urandom_range(0, 8));
      ra  = $urandom;
      run(rop, ra, $urandom, $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3), t);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        @(posedge clk); #1;
        resp_valid = 1'($urandom);
        resp_rdata = $urandom;
      end
      resp_valid = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
